// File: rtl/vram_line_reader.sv
// Read-only VRAM muxer client: fetches a run of consecutive lines through one
// muxer slot and streams each line out as forty 16-bit words over valid/ready.
module vram_line_reader #(
    parameter int LINE_W        = 640,
    parameter int ADDR_W        = 9,
    parameter int WORD_W        = 16,
    parameter int NUM_LINES_MAX = 480
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] first_line,
    input  logic [ADDR_W-1:0] num_lines,
    output logic              busy,
    output logic              done,
    input  logic [LINE_W-1:0] vram_in,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [LINE_W-1:0] vram_out,
    input  logic              vram_turn,
    output logic              activate_write,
    output logic [WORD_W-1:0] word_data,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              word_last,
    output logic [ADDR_W-1:0] word_line,
    output logic [5:0]        word_idx
);

    localparam int                WORDS    = LINE_W / WORD_W;
    localparam logic [5:0]        LAST_IDX = 6'(WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_CNT = ADDR_W'(NUM_LINES_MAX);
    localparam logic [ADDR_W-1:0] LINE_TOP = ADDR_W'(NUM_LINES_MAX - 1);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TURN,
        CAPTURE,
        STREAM,
        FINISH
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [ADDR_W-1:0]  line_ptr;
    logic [ADDR_W-1:0]  remaining;
    logic [5:0]         idx;
    logic [LINE_W-1:0]  line_buf;
    logic               accept;
    logic               line_end;

    assign accept   = word_valid & word_ready;
    assign line_end = accept & (idx == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: state_n gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:      if (start) state_n = (num_lines == '0) ? FINISH : WAIT_TURN;
            WAIT_TURN: if (vram_turn) state_n = CAPTURE;
            CAPTURE:   state_n = STREAM;
            STREAM:    if (line_end) state_n = (remaining == ONE) ? FINISH : WAIT_TURN;
            FINISH:    state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            line_ptr  <= '0;
            remaining <= '0;
            idx       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        // Out-of-range start lines fold back into the visible area.
                        line_ptr  <= (first_line >= LINE_CNT) ? first_line - LINE_CNT : first_line;
                        remaining <= num_lines;
                    end
                end
                CAPTURE: idx <= '0;
                STREAM: begin
                    if (line_end) begin
                        idx       <= '0;
                        remaining <= remaining - ONE;
                        if (remaining != ONE) begin
                            line_ptr <= (line_ptr == LINE_TOP) ? '0 : line_ptr + ONE;
                        end
                    end else if (accept) begin
                        idx <= idx + 6'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the line buffer carries no reset; it is only read while word_valid
    // is high, which always follows a CAPTURE that overwrote all of it.
    always_ff @(posedge clk) begin
        if (state == CAPTURE) begin
            line_buf <= vram_in;
        end
    end

    assign busy           = (state == WAIT_TURN) || (state == CAPTURE) || (state == STREAM);
    assign done           = (state == FINISH);
    assign word_valid     = (state == STREAM);
    assign word_data      = word_valid ? line_buf[int'(idx) * WORD_W +: WORD_W] : '0;
    assign word_last      = word_valid && (idx == LAST_IDX) && (remaining == ONE);
    assign word_line      = line_ptr;
    assign word_idx       = idx;
    assign vram_addr      = line_ptr;
    assign vram_out       = '0;
    assign activate_write = 1'b0;

endmodule

// File: tb/tb_vram_line_reader.sv
// Directed bench for vram_line_reader: BRAM-latency VRAM model, grant and
// ready generators, and a negedge monitor that records every accepted word.
module tb_vram_line_reader;

    logic         clk;
    logic         rst;
    logic         start;
    logic [8:0]   first_line;
    logic [8:0]   num_lines;
    logic         busy;
    logic         done;
    logic [639:0] vram_in;
    logic [8:0]   vram_addr;
    logic [639:0] vram_out;
    logic         vram_turn;
    logic         activate_write;
    logic [15:0]  word_data;
    logic         word_valid;
    logic         word_ready;
    logic         word_last;
    logic [8:0]   word_line;
    logic [5:0]   word_idx;

    vram_line_reader dut (
        .clk(clk), .rst(rst), .start(start), .first_line(first_line),
        .num_lines(num_lines), .busy(busy), .done(done), .vram_in(vram_in),
        .vram_addr(vram_addr), .vram_out(vram_out), .vram_turn(vram_turn),
        .activate_write(activate_write), .word_data(word_data),
        .word_valid(word_valid), .word_ready(word_ready), .word_last(word_last),
        .word_line(word_line), .word_idx(word_idx)
    );

    int checks   = 0;
    int failures = 0;

    logic [639:0] mem [0:479];

    logic        grant_auto   = 1'b1;
    logic        turn_manual  = 1'b0;
    logic [3:0]  grant_cnt    = '0;
    logic        rand_mode    = 1'b0;
    logic        ready_manual = 1'b1;
    logic [15:0] lfsr         = 16'hACE1;

    assign vram_turn  = grant_auto ? (grant_cnt[1:0] == 2'b00) : turn_manual;
    assign word_ready = rand_mode ? lfsr[0] : ready_manual;

    int cyc        = 0;
    int done_cnt   = 0;
    int valid_cnt  = 0;
    int stall_err  = 0;
    int stall_seen = 0;
    logic [15:0] q_data [$];
    logic [8:0]  q_line [$];
    logic [5:0]  q_idx  [$];
    logic        q_last [$];
    int          q_cyc  [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            grant_cnt = grant_cnt + 4'd1;
            lfsr      = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // One-cycle read latency: address seen in cycle N returns data in N+1.
    initial begin
        logic [8:0] a;
        vram_in = '0;
        forever begin
            @(negedge clk);
            a = vram_addr;
            @(posedge clk);
            #1;
            vram_in = (a < 9'd480) ? mem[a] : '0;
        end
    end

    initial begin
        logic        have_hold;
        logic [15:0] h_data;
        logic [8:0]  h_line;
        logic [5:0]  h_idx;
        logic        h_last;
        have_hold = 1'b0;
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            if (!rst) begin
                have_hold = 1'b0;
            end else begin
                if (done) done_cnt = done_cnt + 1;
                if (word_valid) valid_cnt = valid_cnt + 1;
                if (have_hold && (!word_valid || word_data !== h_data || word_line !== h_line ||
                                  word_idx !== h_idx || word_last !== h_last))
                    stall_err = stall_err + 1;
                have_hold = 1'b0;
                if (word_valid && word_ready) begin
                    q_data.push_back(word_data);
                    q_line.push_back(word_line);
                    q_idx.push_back(word_idx);
                    q_last.push_back(word_last);
                    q_cyc.push_back(cyc);
                end else if (word_valid) begin
                    stall_seen = stall_seen + 1;
                    have_hold  = 1'b1;
                    h_data = word_data;
                    h_line = word_line;
                    h_idx  = word_idx;
                    h_last = word_last;
                end
            end
        end
    end

    function automatic logic [15:0] pattern(input logic [8:0] line, input logic [5:0] i);
        return {line, i, 1'b1};
    endfunction

    task automatic clear_q();
        q_data.delete(); q_line.delete(); q_idx.delete(); q_last.delete(); q_cyc.delete();
    endtask

    // Returns just after edge E, the edge that samples start.
    task automatic issue(input logic [8:0] fl, input logic [8:0] nl);
        @(posedge clk);
        #1;
        start = 1'b1; first_line = fl; num_lines = nl;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int limit, input string name);
        int n = 0;
        while (done_cnt == d0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_cnt == d0) begin
            failures++;
            $display("FAIL %s_timeout: no done within %0d cycles", name, limit);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({busy, done, word_valid, word_last} !== 4'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 0000", {busy, done, word_valid, word_last});
        end
        checks++;
        if ({word_data, word_line, word_idx, vram_addr} !== 40'h0) begin
            failures++;
            $display("FAIL reset_values: got %h expected 0", {word_data, word_line, word_idx, vram_addr});
        end
        checks++;
        if ({vram_out, activate_write} !== 641'h0) begin
            failures++;
            $display("FAIL reset_write_side: write outputs nonzero");
        end
    endtask

    task automatic test_single_line();
        int d0, bad, nlast, last_pos;
        grant_auto = 1'b1; rand_mode = 1'b0; ready_manual = 1'b1;
        clear_q();
        d0 = done_cnt;
        issue(9'd5, 9'd1);
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL single_busy: got %b expected 1", busy);
        end
        wait_done(d0, 1000, "single");
        checks++;
        if (q_data.size() != 40) begin
            failures++;
            $display("FAIL single_count: got %0d expected 40", q_data.size());
        end
        checks++;
        if (q_data[3] !== 16'h1234) begin
            failures++;
            $display("FAIL single_word3: got %h expected 1234", q_data[3]);
        end
        bad = 0; nlast = 0; last_pos = -1;
        foreach (q_data[i]) begin
            if (i != 3 && q_data[i] !== 16'hA5A5) bad++;
            if (q_idx[i] !== 6'(i) || q_line[i] !== 9'd5) bad++;
            if (q_last[i]) begin nlast++; last_pos = i; end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL single_words: got %0d bad words expected 0", bad);
        end
        checks++;
        if (nlast != 1 || last_pos != 39) begin
            failures++;
            $display("FAIL single_last: got %0d at %0d expected 1 at 39", nlast, last_pos);
        end
        checks++;
        if (q_cyc[39] - q_cyc[0] != 39) begin
            failures++;
            $display("FAIL single_burst: got span %0d expected 39", q_cyc[39] - q_cyc[0]);
        end
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL single_done: got %0d pulses busy %b expected 1 busy 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] r_data [$];
        logic [8:0]  r_line [$];
        int d0, s0, bad;
        grant_auto = 1'b1; rand_mode = 1'b0; ready_manual = 1'b1;
        clear_q();
        d0 = done_cnt;
        issue(9'd10, 9'd2);
        wait_done(d0, 2000, "bp_ref");
        r_data = q_data;
        r_line = q_line;
        clear_q();
        d0 = done_cnt; s0 = stall_err; stall_seen = 0;
        rand_mode = 1'b1;
        issue(9'd10, 9'd2);
        wait_done(d0, 5000, "bp_rand");
        rand_mode = 1'b0;
        checks++;
        if (q_data.size() != 80 || r_data.size() != 80) begin
            failures++;
            $display("FAIL bp_count: got %0d/%0d expected 80/80", r_data.size(), q_data.size());
        end
        bad = 0;
        foreach (q_data[i]) begin
            if (q_data[i] !== r_data[i] || q_line[i] !== r_line[i]) bad++;
            if (q_data[i] !== pattern(9'(10 + i / 40), 6'(i % 40))) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL bp_sequence: got %0d differing words expected 0", bad);
        end
        checks++;
        if (stall_err != s0 || stall_seen == 0) begin
            failures++;
            $display("FAIL bp_stable: got %0d unstable stalls of %0d expected 0 of >0", stall_err - s0, stall_seen);
        end
    endtask

    task automatic test_wrap();
        int d0, bad, nlast;
        logic [8:0] exp_line;
        grant_auto = 1'b1; ready_manual = 1'b1;
        clear_q();
        d0 = done_cnt;
        issue(9'd478, 9'd3);
        wait_done(d0, 3000, "wrap");
        checks++;
        if (q_data.size() != 120) begin
            failures++;
            $display("FAIL wrap_count: got %0d expected 120", q_data.size());
        end
        bad = 0; nlast = 0;
        foreach (q_data[i]) begin
            exp_line = (i < 40) ? 9'd478 : (i < 80) ? 9'd479 : 9'd0;
            if (q_line[i] !== exp_line || q_idx[i] !== 6'(i % 40)) bad++;
            if (q_data[i] !== pattern(exp_line, 6'(i % 40))) bad++;
            if (q_last[i] !== (i == 119)) nlast++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL wrap_order: got %0d bad words expected 0", bad);
        end
        checks++;
        if (nlast != 0) begin
            failures++;
            $display("FAIL wrap_last: got %0d misplaced last flags expected 0", nlast);
        end
        checks++;
        if (done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL wrap_done: got %0d pulses expected 1", done_cnt - d0);
        end
    endtask

    task automatic test_zero();
        int d0, v0;
        d0 = done_cnt; v0 = valid_cnt;
        issue(9'd7, 9'd0);
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL zero_done: got done %b busy %b expected 1 0", done, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_pulse: got done %b expected 0", done);
        end
        repeat (20) @(negedge clk);
        checks++;
        if (valid_cnt != v0 || done_cnt - d0 != 1) begin
            failures++;
            $display("FAIL zero_quiet: got %0d valid %0d done expected 0 1", valid_cnt - v0, done_cnt - d0);
        end
    endtask

    task automatic test_busy_start();
        int d0, bad;
        grant_auto = 1'b1; ready_manual = 1'b1;
        clear_q();
        d0 = done_cnt;
        issue(9'd20, 9'd1);
        repeat (3) @(negedge clk);
        issue(9'd100, 9'd1);
        wait_done(d0, 1000, "busy");
        repeat (80) @(negedge clk);
        bad = 0;
        foreach (q_line[i]) if (q_line[i] !== 9'd20) bad++;
        checks++;
        if (q_data.size() != 40 || bad != 0) begin
            failures++;
            $display("FAIL busy_ignore: got %0d words %0d foreign expected 40 0", q_data.size(), bad);
        end
        checks++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_done: got %0d pulses busy %b expected 1 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_grant_timing();
        int d0, bad;
        grant_auto = 1'b0; turn_manual = 1'b0; ready_manual = 1'b1;
        clear_q();
        d0 = done_cnt;
        issue(9'd30, 9'd1);
        bad = 0;
        repeat (50) begin
            @(negedge clk);
            if (vram_addr !== 9'd30 || word_valid !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL grant_hold: got %0d unstable cycles expected 0", bad);
        end
        @(posedge clk);
        #1 turn_manual = 1'b1;
        @(negedge clk);
        checks++;
        if (word_valid !== 1'b0) begin
            failures++;
            $display("FAIL grant_n: got valid %b expected 0", word_valid);
        end
        @(posedge clk);
        #1 turn_manual = 1'b0;
        @(negedge clk);
        checks++;
        if (word_valid !== 1'b0) begin
            failures++;
            $display("FAIL grant_n1: got valid %b expected 0", word_valid);
        end
        @(negedge clk);
        checks++;
        if (word_valid !== 1'b1 || word_idx !== 6'd0 || word_data !== pattern(9'd30, 6'd0)) begin
            failures++;
            $display("FAIL grant_n2: got valid %b idx %0d data %h expected 1 0 %h",
                     word_valid, word_idx, word_data, pattern(9'd30, 6'd0));
        end
        wait_done(d0, 200, "grant");
        grant_auto = 1'b1;
    endtask

    task automatic test_reset_mid();
        int d0, n;
        grant_auto = 1'b1; ready_manual = 1'b1;
        issue(9'd40, 9'd2);
        n = 0;
        while (!(word_valid && word_idx >= 6'd10) && n < 500) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(word_valid && word_idx >= 6'd10)) begin
            failures++;
            $display("FAIL rstmid_timeout: stream not reached in %0d cycles", n);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checks++;
        if ({busy, done, word_valid, word_last, word_data, word_line, word_idx, vram_addr} !== 44'h0) begin
            failures++;
            $display("FAIL rstmid_values: got %h expected 0",
                     {busy, done, word_valid, word_last, word_data, word_line, word_idx, vram_addr});
        end
        d0 = done_cnt;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (60) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || word_valid !== 1'b0 || done_cnt != d0) begin
            failures++;
            $display("FAIL rstmid_idle: got busy %b valid %b done %0d expected 0 0 0",
                     busy, word_valid, done_cnt - d0);
        end
    endtask

    initial begin
        logic [15:0] w;
        rst = 1'b0; start = 1'b0; first_line = '0; num_lines = '0;
        for (int l = 0; l < 480; l++)
            for (int i = 0; i < 40; i++)
                mem[l][16 * i +: 16] = pattern(9'(l), 6'(i));
        for (int i = 0; i < 40; i++) begin
            w = (i == 3) ? 16'h1234 : 16'hA5A5;
            mem[5][16 * i +: 16] = w;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        test_reset();
        test_single_line();
        test_backpressure();
        test_wrap();
        test_zero();
        test_busy_start();
        test_grant_timing();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
